// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron classify path: class codes,
// feeder FSM encoding and default geometry.
package perceptron_pkg;

  localparam int DEFAULT_WIDTH   = 25;
  localparam int DEFAULT_TIMEOUT = 64;

  localparam logic [1:0] CLS_NONE   = 2'b00;
  localparam logic [1:0] CLS_CIRCLE = 2'b01;
  localparam logic [1:0] CLS_CROSS  = 2'b10;
  localparam logic [1:0] CLS_ERR    = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_CLASSIFY = 2'd2,
    ST_REPORT   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/perceptron_frame_loader.sv
// Pixel counter and indexed frame register; flags short, exact and long
// frames on the pixel that ends or overruns the frame.
module perceptron_frame_loader
  import perceptron_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_accept,
  input  logic             i_data,
  input  logic             i_last,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_frame,
  output logic             o_short,
  output logic             o_full,
  output logic             o_long
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_frame;
  logic             w_atEnd;

  assign w_atEnd = (r_cnt == LAST_IDX);
  assign o_short = i_accept & i_last & (r_cnt < LAST_IDX);
  assign o_full  = i_accept & i_last & w_atEnd;
  assign o_long  = i_accept & ~i_last & w_atEnd;
  assign o_frame = r_frame;

  // Bits are never cleared between frames; a full frame rewrites all of them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_frame <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_cnt == CW'(i)) r_frame[i] <= i_data;
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_frame_feeder.sv
// Initiator side of the perceptron classify interface: assembles a serial
// pixel frame, drives the classifier, and reports the class code.
module perceptron_frame_feeder
  import perceptron_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_valid,
  input  logic             i_pix_data,
  input  logic             i_pix_last,
  output logic             o_pix_ready,
  output logic [WIDTH-1:0] o_cls_frame,
  output logic             o_cls_en,
  input  logic [1:0]       i_cls_out,
  input  logic             i_cls_ready,
  output logic             o_res_valid,
  output logic [1:0]       o_res_class,
  output logic             o_res_err,
  input  logic             i_res_ready,
  output logic [7:0]       o_frame_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  feeder_state_t r_state, w_stateNext;
  logic [TW-1:0] r_timer, w_timerNext;
  logic          r_clsEn, w_clsEnNext;
  logic          r_resValid, w_resValidNext;
  logic [1:0]    r_resClass, w_resClassNext;
  logic          r_resErr, w_resErrNext;
  logic [7:0]    r_frameCnt, w_frameCntNext;

  logic w_accept;
  logic w_loadAccept;
  logic w_handshake;
  logic w_short;
  logic w_full;
  logic w_long;

  assign o_pix_ready  = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign w_accept     = i_pix_valid & o_pix_ready;
  assign w_loadAccept = w_accept & (r_state == ST_LOAD);
  assign w_handshake  = (r_state == ST_REPORT) & r_resValid & i_res_ready;

  perceptron_frame_loader #(.WIDTH(WIDTH)) u_loader (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_accept (w_loadAccept),
    .i_data   (i_pix_data),
    .i_last   (i_pix_last),
    .i_clear  (w_handshake),
    .o_frame  (o_cls_frame),
    .o_short  (w_short),
    .o_full   (w_full),
    .o_long   (w_long)
  );

  always_comb begin
    w_stateNext    = r_state;
    w_timerNext    = r_timer;
    w_clsEnNext    = r_clsEn;
    w_resValidNext = r_resValid;
    w_resClassNext = r_resClass;
    w_resErrNext   = r_resErr;
    w_frameCntNext = r_frameCnt;
    case (r_state)
      ST_LOAD: begin
        if (w_short) begin
          w_stateNext    = ST_REPORT;
          w_resValidNext = 1'b1;
          w_resClassNext = CLS_ERR;
          w_resErrNext   = 1'b1;
        end else if (w_full) begin
          w_stateNext = ST_CLASSIFY;
          w_clsEnNext = 1'b1;
          w_timerNext = '0;
        end else if (w_long) begin
          w_stateNext = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_accept && i_pix_last) begin
          w_stateNext    = ST_REPORT;
          w_resValidNext = 1'b1;
          w_resClassNext = CLS_ERR;
          w_resErrNext   = 1'b1;
        end
      end
      // A strobe arriving on the timeout cycle still counts as a valid result.
      ST_CLASSIFY: begin
        w_timerNext = r_timer + 1'b1;
        if (i_cls_ready) begin
          w_stateNext    = ST_REPORT;
          w_clsEnNext    = 1'b0;
          w_resValidNext = 1'b1;
          w_resClassNext = i_cls_out;
          w_resErrNext   = 1'b0;
        end else if (r_timer == TIMER_MAX) begin
          w_stateNext    = ST_REPORT;
          w_clsEnNext    = 1'b0;
          w_resValidNext = 1'b1;
          w_resClassNext = CLS_ERR;
          w_resErrNext   = 1'b1;
        end
      end
      ST_REPORT: begin
        if (w_handshake) begin
          w_stateNext    = ST_LOAD;
          w_resValidNext = 1'b0;
          w_frameCntNext = r_frameCnt + 8'd1;
        end
      end
      default: w_stateNext = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_LOAD;
      r_timer    <= '0;
      r_clsEn    <= 1'b0;
      r_resValid <= 1'b0;
      r_resClass <= CLS_NONE;
      r_resErr   <= 1'b0;
      r_frameCnt <= 8'd0;
    end else begin
      r_state    <= w_stateNext;
      r_timer    <= w_timerNext;
      r_clsEn    <= w_clsEnNext;
      r_resValid <= w_resValidNext;
      r_resClass <= w_resClassNext;
      r_resErr   <= w_resErrNext;
      r_frameCnt <= w_frameCntNext;
    end
  end

  assign o_cls_en    = r_clsEn;
  assign o_res_valid = r_resValid;
  assign o_res_class = r_resClass;
  assign o_res_err   = r_resErr;
  assign o_frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_perceptron_frame_feeder.sv
// Self-checking bench for perceptron_frame_feeder: a frame-level model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_perceptron_frame_feeder;
  import perceptron_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixValid, pixData, pixLast, pixReady;
  logic [24:0] clsFrame;
  logic        clsEn;
  logic [1:0]  clsOut;
  logic        clsReady;
  logic        resValid;
  logic [1:0]  resClass;
  logic        resErr;
  logic        resReady;
  logic [7:0]  frameCnt;

  int compared   = 0;
  int mismatched = 0;
  int enCount    = 0;
  bit checkEn    = 1'b0;

  // Frame-level model state
  bit          mCollecting;
  int          nPix;
  logic [24:0] mFrame;
  bit          mClassify;
  int          mWait;
  bit          mResValid;
  logic [1:0]  mClass;
  bit          mErr;
  int          mFrames;

  perceptron_frame_feeder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pix_valid (pixValid),
    .i_pix_data  (pixData),
    .i_pix_last  (pixLast),
    .o_pix_ready (pixReady),
    .o_cls_frame (clsFrame),
    .o_cls_en    (clsEn),
    .i_cls_out   (clsOut),
    .i_cls_ready (clsReady),
    .o_res_valid (resValid),
    .o_res_class (resClass),
    .o_res_err   (resErr),
    .i_res_ready (resReady),
    .o_frame_cnt (frameCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched < 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: wait expired, got no event, expected one at %0t", name, $time);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Pixel-count view of a frame: what arrives before pix_last decides the outcome.
  always @(posedge clk) begin
    if (rst) begin
      mCollecting = 1'b1;
      nPix        = 0;
      mFrame      = '0;
      mClassify   = 1'b0;
      mWait       = 0;
      mResValid   = 1'b0;
      mClass      = CLS_NONE;
      mErr        = 1'b0;
      mFrames     = 0;
    end else if (mCollecting) begin
      if (pixValid) begin
        if (nPix < 25) mFrame[nPix] = pixData;
        nPix++;
        if (pixLast) begin
          mCollecting = 1'b0;
          if (nPix == 25) begin
            mClassify = 1'b1;
            mWait     = 0;
          end else begin
            mResValid = 1'b1;
            mClass    = CLS_ERR;
            mErr      = 1'b1;
          end
        end
      end
    end else if (mClassify) begin
      if (clsReady) begin
        mClassify = 1'b0;
        mResValid = 1'b1;
        mClass    = clsOut;
        mErr      = 1'b0;
      end else begin
        mWait++;
        if (mWait == 64) begin
          mClassify = 1'b0;
          mResValid = 1'b1;
          mClass    = CLS_ERR;
          mErr      = 1'b1;
        end
      end
    end else if (mResValid && resReady) begin
      mResValid   = 1'b0;
      mFrames     = (mFrames + 1) % 256;
      mCollecting = 1'b1;
      nPix        = 0;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("pix_ready", 32'(pixReady), 32'(mCollecting));
      checkOutput("cls_frame", 32'(clsFrame), 32'(mFrame));
      checkOutput("cls_en", 32'(clsEn), 32'(mClassify));
      checkOutput("res_valid", 32'(resValid), 32'(mResValid));
      checkOutput("res_class", 32'(resClass), 32'(mClass));
      checkOutput("res_err", 32'(resErr), 32'(mErr));
      checkOutput("frame_cnt", 32'(frameCnt), 32'(mFrames));
    end
    if (clsEn) enCount++;
  end

  task automatic applyStimulus(input int n, input logic [31:0] bits, input bit withLast);
    int b = 0;
    while (!pixReady && b < 200) begin tick; b++; end
    if (!pixReady) flagTimeout("pix_ready wait");
    for (int i = 0; i < n; i++) begin
      pixValid = 1'b1;
      pixData  = bits[i];
      pixLast  = withLast && (i == n - 1);
      tick;
    end
    pixValid = 1'b0;
    pixData  = 1'b0;
    pixLast  = 1'b0;
  endtask

  task automatic waitClsEn;
    int b = 0;
    while (!clsEn && b < 100) begin tick; b++; end
    if (!clsEn) flagTimeout("cls_en wait");
  endtask

  // Strobe cls_ready on the k-th cycle that cls_en is high (k=0: never).
  task automatic classify(input int k, input logic [1:0] cls);
    int b = 0;
    waitClsEn;
    if (k > 0) begin
      repeat (k - 1) begin clsOut = 2'b11; tick; end
      clsReady = 1'b1;
      clsOut   = cls;
      tick;
      clsReady = 1'b0;
      clsOut   = 2'b00;
    end else begin
      while (clsEn && b < 200) begin tick; b++; end
      if (clsEn) flagTimeout("cls_en drop wait");
    end
  endtask

  task automatic waitResult;
    int b = 0;
    while (!resValid && b < 200) begin tick; b++; end
    if (!resValid) flagTimeout("res_valid wait");
  endtask

  task automatic releaseResult(input int hold);
    repeat (hold) tick;
    resReady = 1'b1;
    tick;
    resReady = 1'b0;
  endtask

  task automatic doReset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " pix_ready"}, 32'(pixReady), 32'd1);
    checkOutput({tag, " cls_en"}, 32'(clsEn), 32'd0);
    checkOutput({tag, " res_valid"}, 32'(resValid), 32'd0);
    checkOutput({tag, " res_class"}, 32'(resClass), 32'd0);
    checkOutput({tag, " res_err"}, 32'(resErr), 32'd0);
    checkOutput({tag, " frame_cnt"}, 32'(frameCnt), 32'd0);
    checkOutput({tag, " cls_frame"}, 32'(clsFrame), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation ran past time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; pixValid = 1'b0; pixData = 1'b0; pixLast = 1'b0;
    clsOut = 2'b00; clsReady = 1'b0; resReady = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    checkEn = 1'b1;
    checkResetValues("reset");

    // Cross image, classifier answers on the 25th enabled cycle
    enCount = 0;
    applyStimulus(25, 32'h1101011, 1'b1);
    classify(25, CLS_CROSS);
    waitResult;
    checkOutput("cross frame", 32'(clsFrame), 32'h1101011);
    checkOutput("cross class", 32'(resClass), 32'(CLS_CROSS));
    checkOutput("cross err", 32'(resErr), 32'd0);
    checkOutput("cross en cycles", 32'(enCount), 32'd25);
    releaseResult(0);
    checkOutput("cross frame_cnt", 32'(frameCnt), 32'd1);

    // Stray strobe in LOAD, then a short frame
    enCount = 0;
    clsReady = 1'b1; clsOut = CLS_CIRCLE; tick; clsReady = 1'b0; clsOut = 2'b00;
    applyStimulus(10, 32'h3FF, 1'b1);
    waitResult;
    checkOutput("short class", 32'(resClass), 32'(CLS_ERR));
    checkOutput("short err", 32'(resErr), 32'd1);
    checkOutput("short no cls_en", 32'(enCount), 32'd0);
    releaseResult(0);
    checkOutput("short back to load", 32'(pixReady), 32'd1);

    // Long frame: pixels 26-30 dropped
    enCount = 0;
    applyStimulus(30, 32'h3F555555, 1'b1);
    waitResult;
    checkOutput("long frame", 32'(clsFrame), 32'h1555555);
    checkOutput("long class", 32'(resClass), 32'(CLS_ERR));
    checkOutput("long err", 32'(resErr), 32'd1);
    checkOutput("long no cls_en", 32'(enCount), 32'd0);
    releaseResult(0);

    // Timeout, then a strobe exactly on the last allowed cycle
    enCount = 0;
    applyStimulus(25, 32'h0AAAAAA, 1'b1);
    classify(0, CLS_NONE);
    waitResult;
    checkOutput("timeout en cycles", 32'(enCount), 32'd64);
    checkOutput("timeout class", 32'(resClass), 32'(CLS_ERR));
    checkOutput("timeout err", 32'(resErr), 32'd1);
    releaseResult(0);
    enCount = 0;
    applyStimulus(25, 32'h1F00000, 1'b1);
    classify(64, CLS_CIRCLE);
    waitResult;
    checkOutput("edge en cycles", 32'(enCount), 32'd64);
    checkOutput("edge class", 32'(resClass), 32'(CLS_CIRCLE));
    checkOutput("edge err", 32'(resErr), 32'd0);
    releaseResult(0);
    checkOutput("five frames", 32'(frameCnt), 32'd5);

    // Backpressure on the result port
    applyStimulus(25, 32'h1101011, 1'b1);
    classify(3, CLS_CROSS);
    waitResult;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp pix_ready", 32'(pixReady), 32'd0);
      checkOutput("bp frame_cnt", 32'(frameCnt), 32'd5);
      checkOutput("bp class", 32'(resClass), 32'(CLS_CROSS));
      tick;
    end
    releaseResult(0);
    checkOutput("bp frame_cnt after", 32'(frameCnt), 32'd6);

    // 256 one-pixel frames wrap the counter
    doReset;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 32'h1, 1'b1);
      waitResult;
      releaseResult(0);
      if (i == 254) checkOutput("cnt at 255", 32'(frameCnt), 32'd255);
    end
    checkOutput("cnt wrapped", 32'(frameCnt), 32'd0);

    // Reset in CLASSIFY, then in LOAD, then a clean frame
    applyStimulus(25, 32'h1FFFFFF, 1'b1);
    waitClsEn;
    repeat (5) tick;
    doReset;
    checkResetValues("rst classify");
    applyStimulus(12, 32'hFFF, 1'b0);
    doReset;
    checkResetValues("rst load");
    applyStimulus(25, 32'h1101011, 1'b1);
    classify(7, CLS_CROSS);
    waitResult;
    checkOutput("post-reset frame", 32'(clsFrame), 32'h1101011);
    checkOutput("post-reset class", 32'(resClass), 32'(CLS_CROSS));
    releaseResult(0);
    checkOutput("post-reset cnt", 32'(frameCnt), 32'd1);

    repeat (3) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
